// File: rtl/reg_file.sv
// reg_file: architectural register file for the multi-cycle MIPS core.
// 2^ADDR_WIDTH registers of DATA_WIDTH bits. Two combinational read ports,
// one write port on the rising clock edge. Register 0 is hardwired to zero.
// Optional macro REGFILE_BYPASS_EN: same-cycle forwarding from the write
// port to a read port whose address matches write_addr.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  write_en,
  input  logic                  clk,
  input  logic                  reset_n
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Entry 0 is reset to zero and never written, so it is constant; the read
  // muxes also force zero for address 0 so no tool has to prove that.
  logic [DATA_WIDTH-1:0] r_regs [DEPTH];

  logic                  w_wr_ok;
  logic [DATA_WIDTH-1:0] w_stored_a;
  logic [DATA_WIDTH-1:0] w_stored_b;

  assign w_wr_ok = write_en && (write_addr != '0);

  // Register storage: async clear, write on rising edge when enabled and nonzero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[write_addr] <= write_data;
    end
  end

  // Stored-value read path, address 0 always returns zero.
  always_comb begin
    w_stored_a = '0;
    w_stored_b = '0;
    if (read_addr_a != '0) w_stored_a = r_regs[read_addr_a];
    if (read_addr_b != '0) w_stored_b = r_regs[read_addr_b];
  end

`ifdef REGFILE_BYPASS_EN
  logic w_byp_a;
  logic w_byp_b;

  // Forwarding is suppressed in reset so outputs track the cleared storage.
  assign w_byp_a = reset_n && w_wr_ok && (read_addr_a == write_addr);
  assign w_byp_b = reset_n && w_wr_ok && (read_addr_b == write_addr);

  assign read_data_a = w_byp_a ? write_data : w_stored_a;
  assign read_data_b = w_byp_b ? write_data : w_stored_b;
`else
  assign read_data_a = w_stored_a;
  assign read_data_b = w_stored_b;
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file. Expected port values come from
// a bench-side register model and are queued when reads are driven, then
// popped and compared once the combinational outputs settle.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic [DW-1:0] read_data_a, read_data_b, write_data;
  logic [AW-1:0] read_addr_a, read_addr_b, write_addr;
  logic          write_en, clk, reset_n;

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .read_data_a (read_data_a),
    .read_data_b (read_data_b),
    .write_data  (write_data),
    .read_addr_a (read_addr_a),
    .read_addr_b (read_addr_b),
    .write_addr  (write_addr),
    .write_en    (write_en),
    .clk         (clk),
    .reset_n     (reset_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] model [32];
  logic [DW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue both expectations, let outputs settle, then pop and compare.
  task automatic expect_ports(input string tag, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    exp_q.push_back(ea);
    exp_q.push_back(eb);
    #1;
    chk({tag, "_a"}, read_data_a, exp_q.pop_front());
    chk({tag, "_b"}, read_data_b, exp_q.pop_front());
  endtask

  task automatic sb_read(input string tag, input int a, input int b);
    read_addr_a = AW'(a);
    read_addr_b = AW'(b);
    expect_ports(tag, (a == 0) ? '0 : model[a], (b == 0) ? '0 : model[b]);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic en);
    @(negedge clk);
    write_addr = AW'(a);
    write_data = d;
    write_en   = en;
    @(posedge clk);
    if (en && a != 0 && reset_n) model[a] = d;
    #1;
    write_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    reset_n = 1'b0;
    write_en = 1'b0;
    write_data = '0;
    write_addr = '0;
    read_addr_a = '0;
    read_addr_b = '0;
    #12;
    sb_read("rst_init", 5, 31);
    @(negedge clk);
    reset_n = 1'b1;

    // Async reset mid-cycle clears r5 without a clock edge.
    wr(5, 32'hDEADBEEF, 1'b1);
    sb_read("r5_written", 5, 5);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    sb_read("rst_async", 5, 0);
    for (int i = 0; i < 32; i++) sb_read("rst_all", i, 31 - i);

    // Write held high across an edge while in reset is ignored.
    write_en = 1'b1;
    write_addr = 5'd9;
    write_data = 32'hCAFE0009;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    sb_read("rst_wr_ignored", 9, 9);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic write/read on successive edges.
    wr(7, 32'h12345678, 1'b1);
    wr(8, 32'hFFFFFFFF, 1'b1);
    sb_read("r7_r8", 7, 8);
    expect_ports("r7_r8_const", 32'h12345678, 32'hFFFFFFFF);

    // r0 writes are discarded.
    wr(0, 32'hAAAA5555, 1'b1);
    sb_read("r0", 0, 0);
    expect_ports("r0_const", '0, '0);

    // JAL link register, then a disabled write must not change it.
    wr(31, 32'h00000104, 1'b1);
    sb_read("jal", 31, 7);
    wr(31, 32'h00000999, 1'b0);
    sb_read("jal_hold", 31, 31);
    expect_ports("jal_hold_const", 32'h00000104, 32'h00000104);

    // Same-cycle read/write of r3.
    wr(3, 32'h00000011, 1'b1);
    @(negedge clk);
    write_addr = 5'd3;
    write_data = 32'h00000022;
    write_en = 1'b1;
    read_addr_a = 5'd3;
    read_addr_b = 5'd7;
`ifdef REGFILE_BYPASS_EN
    expect_ports("same_cyc_pre", 32'h00000022, 32'h12345678);
`else
    expect_ports("same_cyc_pre", 32'h00000011, 32'h12345678);
`endif
    @(posedge clk);
    model[3] = 32'h00000022;
    #1;
    write_en = 1'b0;
    expect_ports("same_cyc_post", 32'h00000022, 32'h12345678);

    // Exhaustive sweep of all register pairs.
    for (int i = 1; i < 32; i++) wr(i, 32'(i) * 32'h01010101, 1'b1);
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++)
        sb_read("sweep", a, b);
    read_addr_a = 5'd17;
    read_addr_b = 5'd0;
    expect_ports("sweep_const", 32'h11111111, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
